// File: rtl/rca_36_pkg.sv
// Shared constants for the 36-bit registered ripple-carry adder.
package rca_36_pkg;

  localparam int RCA_WIDTH = 36;

endpackage : rca_36_pkg

// File: rtl/rca_36_full_adder.sv
// Single-bit full-adder cell.
// The top level chains these cells to form the ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/rca_36.sv
// 36-bit ripple-carry adder built from a full-adder chain.
// The sum and carry-out are held in a single output register stage.
module rca_36
  import rca_36_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  assign carry[0] = Cin;

  // Each cell takes its carry-in from the cell below it, so carry ripples through every bit.
  for (genvar k = 0; k < WIDTH; k++) begin : g_chain
    full_adder u_fa (
      .a    (A[k]),
      .b    (B[k]),
      .cin  (carry[k]),
      .s    (sum[k]),
      .cout (carry[k+1])
    );
  end

  assign s_d    = sum;
  assign cout_d = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;

endmodule : rca_36

// File: tb/tb_rca_36.sv
// Self-checking bench for rca_36.
// Expected results come from plain 37-bit arithmetic on the applied operands.
module tb_rca_36;

  localparam int W = 36;
  localparam logic [W-1:0] ALL_ONES = 36'hF_FFFF_FFFF;
  localparam logic [W-1:0] MSB_ONLY = 36'h8_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;

  int total = 0;
  int bad   = 0;

  rca_36 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic rstn);
    logic [W:0] r;
    if (!rstn) r = '0;
    else       r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return r;
  endfunction

  // Drives one set of inputs, lets one rising edge capture them, then samples 1 time unit later.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic rstn, input string tag);
    logic [W:0] expected;
    A     = a;
    B     = b;
    Cin   = cin;
    rst_n = rstn;
    expected = refModel(a, b, cin, rstn);
    @(posedge clk);
    #1;
    checkOutput(expected, tag);
  endtask

  task automatic checkOutput(input logic [W:0] expected, input string tag);
    total++;
    assert ({Cout, S} === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got Cout=%b S=%h, expected Cout=%b S=%h",
             tag, Cout, S, expected[W], expected[W-1:0]);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [71:0]  pair;

    A = '0; B = '0; Cin = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    applyStimulus(ALL_ONES, 36'd1, 1'b1, 1'b0, "reset_edge1");
    applyStimulus(ALL_ONES, 36'd1, 1'b1, 1'b0, "reset_edge2");
    applyStimulus(ALL_ONES, 36'd1, 1'b1, 1'b1, "reset_release");

    for (int i = 0; i < 4096; i++) begin
      pair = 72'(i);
      applyStimulus(pair[71:36], pair[35:0], 1'b0, 1'b1, "low_sweep");
    end

    for (int i = 0; i < 4096; i++)
      applyStimulus(W'(i), W'(i + 1), 1'b0, 1'b1, "incr_pairs");

    applyStimulus(MSB_ONLY, MSB_ONLY, 1'b0, 1'b1, "msb_overflow");
    applyStimulus(MSB_ONLY, MSB_ONLY, 1'b1, 1'b1, "msb_overflow_cin");

    applyStimulus(ALL_ONES, '0, 1'b1, 1'b1, "full_ripple");
    applyStimulus(ALL_ONES, ALL_ONES, 1'b1, 1'b1, "ones_plus_ones");
    applyStimulus('0, '0, 1'b1, 1'b1, "cin_only");
    applyStimulus('0, '0, 1'b0, 1'b1, "all_zero");

    // Random back-to-back operands with a single-edge reset dropped into the middle.
    for (int i = 0; i < 200; i++) begin
      ra = {4'($urandom), $urandom};
      rb = {4'($urandom), $urandom};
      rc = 1'($urandom);
      if (i % 8 == 3) begin
        ra[W-1] = 1'b1;
        rb[W-1] = 1'b1;
      end
      if (i == 100) applyStimulus(ra, rb, rc, 1'b0, "midstream_reset");
      else          applyStimulus(ra, rb, rc, 1'b1, "random_stream");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rca_36
